// File: rtl/microsequencer.sv
// Next-state sequencer for the multicycle MIPS control unit: holds the microcode
// ROM address, dispatches on opcode, stalls on memory, traps illegal opcodes.
module microsequencer #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       opcode,
   input  logic [1:0]       addrctl,
   input  logic             mem_ready,
   output logic [3:0]       state,
   output logic             illegal,
   output logic [CNT_W-1:0] instr_count
);

   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEMADR  = 4'd2,
      MEMRD   = 4'd3,
      MEMWB   = 4'd4,
      MEMWR   = 4'd5,
      RTYPEEX = 4'd6,
      RTYPEWB = 4'd7,
      BEQEX   = 4'd8,
      JEX     = 4'd9,
      HALT    = 4'd10
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [1:0] AC_FETCH = 2'b00;
   localparam logic [1:0] AC_DISP1 = 2'b01;
   localparam logic [1:0] AC_DISP2 = 2'b10;
   localparam logic [1:0] AC_SEQ   = 2'b11;

   state_t cur, nxt;
   logic   stall, retire;

   assign state = cur;

   always_comb begin
      nxt   = cur;
      stall = ((cur == FETCH) || (cur == MEMRD) || (cur == MEMWR)) && !mem_ready;
      // HALT and the unused codes 11-15 all sink into HALT
      if (cur >= HALT) begin
         nxt = HALT;
      end else if (stall) begin
         nxt = cur;
      end else begin
         case (addrctl)
            AC_FETCH: nxt = FETCH;
            AC_SEQ:   nxt = state_t'(cur + 4'd1);
            AC_DISP1: begin
               case (opcode)
                  OP_RTYPE: nxt = RTYPEEX;
                  OP_LW:    nxt = MEMADR;
                  OP_SW:    nxt = MEMADR;
                  OP_BEQ:   nxt = BEQEX;
                  OP_J:     nxt = JEX;
                  default:  nxt = HALT;
               endcase
            end
            AC_DISP2: begin
               case (opcode)
                  OP_LW:   nxt = MEMRD;
                  OP_SW:   nxt = MEMWR;
                  default: nxt = HALT;
               endcase
            end
            default: nxt = HALT;
         endcase
      end
      retire = (cur != FETCH) && (nxt == FETCH);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cur         <= FETCH;
         illegal     <= 1'b0;
         instr_count <= '0;
      end else begin
         cur <= nxt;
         if (nxt == HALT)
            illegal <= 1'b1;
         if (retire)
            instr_count <= instr_count + CNT_W'(1);
      end
   end

endmodule
